// File: rtl/tcp_session_ctrl.sv
// Connection-level sequencer for the TCP transmit engine: chooses when a segment
// is sent and which flags it carries (handshake, push/ack, delayed ack, close, retransmit).
module tcp_session_ctrl #(
    parameter int unsigned ACK_DELAY  = 1000000,
    parameter int unsigned RTO_CYCLES = 4000000,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_open_req,
    input  logic       i_close_req,
    input  logic       i_app_valid,
    output logic       o_app_ready,
    input  logic       i_seg_rx_valid,
    input  logic [5:0] i_seg_rx_flags,
    input  logic       i_tx_busy,
    output logic       o_tx_strobe,
    output logic [5:0] o_tx_flag,
    output logic       o_conn_up,
    output logic       o_conn_err,
    output logic [2:0] o_state
);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [31:0]   ACK_LAST  = 32'(ACK_DELAY - 1);
    localparam logic [31:0]   RTO_LAST  = 32'(RTO_CYCLES - 1);

    // Flag encoding {URG,ACK,PUSH,RST,SYN,FIN}
    localparam logic [5:0] F_ACK = 6'b010000;
    localparam logic [5:0] F_PSH = 6'b001000;
    localparam logic [5:0] F_SYN = 6'b000010;
    localparam logic [5:0] F_FIN = 6'b000001;

    typedef enum logic [2:0] {
        S_CLOSED = 3'd0,
        S_SYN    = 3'd1,
        S_EST    = 3'd2,
        S_FIN    = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_tx_strobe;
    logic [5:0]      r_tx_flag;
    logic            r_synack_seen;
    logic            r_fin_seen;
    logic            r_need_ack;
    logic [31:0]     r_ack_cnt;
    logic [31:0]     r_rto_cnt;
    logic [RW-1:0]   r_retry;

    logic w_gate, w_rx_rst, w_rx_synack, w_rx_psh, w_rx_fin;
    logic w_rto_exp, w_ack_due, w_app_acc;
    logic w_unused_urg;

    assign w_gate      = !i_tx_busy && !r_tx_strobe;
    assign w_rx_rst    = i_seg_rx_valid && i_seg_rx_flags[2];
    assign w_rx_synack = i_seg_rx_valid && i_seg_rx_flags[4] && i_seg_rx_flags[1];
    assign w_rx_psh    = i_seg_rx_valid && i_seg_rx_flags[3];
    assign w_rx_fin    = i_seg_rx_valid && i_seg_rx_flags[0];
    assign w_rto_exp   = (r_rto_cnt == RTO_LAST);
    assign w_ack_due   = r_need_ack && (r_ack_cnt == ACK_LAST);
    assign w_app_acc   = i_app_valid && o_app_ready;
    assign w_unused_urg = i_seg_rx_flags[5];

    assign o_app_ready = (r_state == S_EST) && w_gate && !i_close_req;
    assign o_tx_strobe = r_tx_strobe;
    assign o_tx_flag   = r_tx_flag;
    assign o_conn_up   = (r_state == S_EST);
    assign o_conn_err  = (r_state == S_ERROR);
    assign o_state     = r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_CLOSED;
            r_tx_strobe   <= 1'b0;
            r_tx_flag     <= '0;
            r_synack_seen <= 1'b0;
            r_fin_seen    <= 1'b0;
            r_need_ack    <= 1'b0;
            r_ack_cnt     <= '0;
            r_rto_cnt     <= '0;
            r_retry       <= '0;
        end else begin
            r_tx_strobe <= 1'b0;
            r_tx_flag   <= '0;
            // Timers saturate at their last value; state branches below restart them
            if ((r_state == S_SYN || r_state == S_FIN) && !w_rto_exp)
                r_rto_cnt <= r_rto_cnt + 32'd1;
            if (r_need_ack && r_ack_cnt != ACK_LAST)
                r_ack_cnt <= r_ack_cnt + 32'd1;

            case (r_state)
                S_CLOSED, S_ERROR: begin
                    if (i_open_req && w_gate) begin
                        r_tx_strobe   <= 1'b1;
                        r_tx_flag     <= F_SYN;
                        r_state       <= S_SYN;
                        r_retry       <= '0;
                        r_rto_cnt     <= '0;
                        r_synack_seen <= 1'b0;
                    end
                end
                S_SYN: begin
                    if (w_rx_rst) begin
                        r_state <= S_ERROR;
                    end else if (r_synack_seen || w_rx_synack) begin
                        if (w_gate) begin
                            r_tx_strobe   <= 1'b1;
                            r_tx_flag     <= F_ACK;
                            r_state       <= S_EST;
                            r_need_ack    <= 1'b0;
                            r_ack_cnt     <= '0;
                            r_synack_seen <= 1'b0;
                        end else begin
                            r_synack_seen <= 1'b1;
                        end
                    end else if (w_rto_exp) begin
                        if (r_retry == RETRY_MAX) begin
                            r_state <= S_ERROR;
                        end else if (w_gate) begin
                            r_tx_strobe <= 1'b1;
                            r_tx_flag   <= F_SYN;
                            r_retry     <= r_retry + 1'b1;
                            r_rto_cnt   <= '0;
                        end
                    end
                end
                S_EST: begin
                    if (w_rx_rst) begin
                        r_state    <= S_ERROR;
                        r_need_ack <= 1'b0;
                        r_ack_cnt  <= '0;
                    end else if (i_close_req) begin
                        if (w_gate) begin
                            r_tx_strobe <= 1'b1;
                            r_tx_flag   <= F_FIN | F_ACK;
                            r_state     <= S_FIN;
                            r_rto_cnt   <= '0;
                            r_retry     <= '0;
                            r_fin_seen  <= 1'b0;
                            r_need_ack  <= 1'b0;
                            r_ack_cnt   <= '0;
                        end
                    end else begin
                        if (w_app_acc) begin
                            r_tx_strobe <= 1'b1;
                            r_tx_flag   <= F_PSH | (r_need_ack ? F_ACK : 6'b0);
                            r_need_ack  <= 1'b0;
                            r_ack_cnt   <= '0;
                        end else if (w_ack_due && w_gate) begin
                            r_tx_strobe <= 1'b1;
                            r_tx_flag   <= F_ACK;
                            r_need_ack  <= 1'b0;
                            r_ack_cnt   <= '0;
                        end
                        // A new PUSH overrides a same-cycle clear so its ACK is never lost
                        if (w_rx_psh)
                            r_need_ack <= 1'b1;
                    end
                end
                S_FIN: begin
                    if (w_rx_rst) begin
                        r_state <= S_CLOSED;
                    end else if (r_fin_seen || w_rx_fin) begin
                        if (w_gate) begin
                            r_tx_strobe <= 1'b1;
                            r_tx_flag   <= F_ACK;
                            r_state     <= S_CLOSED;
                            r_fin_seen  <= 1'b0;
                        end else begin
                            r_fin_seen <= 1'b1;
                        end
                    end else if (w_rto_exp) begin
                        if (r_retry == RETRY_MAX) begin
                            r_state <= S_ERROR;
                        end else if (w_gate) begin
                            r_tx_strobe <= 1'b1;
                            r_tx_flag   <= F_FIN | F_ACK;
                            r_retry     <= r_retry + 1'b1;
                            r_rto_cnt   <= '0;
                        end
                    end
                end
                default: r_state <= S_CLOSED;
            endcase
        end
    end
endmodule

// File: tb/tb_tcp_session_ctrl.sv
// Scoreboard bench for tcp_session_ctrl: a timestamp-based reference model predicts
// every send; a negedge monitor pops and compares strobes and checks state outputs.
module tb_tcp_session_ctrl;
    localparam int AD  = 8;
    localparam int RTO = 16;
    localparam int MR  = 2;

    localparam logic [5:0] SYN    = 6'b000010;
    localparam logic [5:0] ACK    = 6'b010000;
    localparam logic [5:0] PSH    = 6'b001000;
    localparam logic [5:0] FIN    = 6'b000001;
    localparam logic [5:0] RSTF   = 6'b000100;
    localparam logic [5:0] SYNACK = 6'b010010;
    localparam logic [5:0] FINACK = 6'b010001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       open_req = 1'b0, close_req = 1'b0, app_valid = 1'b0;
    logic       seg_rx_valid = 1'b0;
    logic [5:0] seg_rx_flags = '0;
    logic       tx_busy = 1'b0;
    logic       app_ready, tx_strobe, conn_up, conn_err;
    logic [5:0] tx_flag;
    logic [2:0] state;

    tcp_session_ctrl #(.ACK_DELAY(AD), .RTO_CYCLES(RTO), .MAX_RETRY(MR)) dut (
        .i_clk(clk), .i_rst(rst), .i_open_req(open_req), .i_close_req(close_req),
        .i_app_valid(app_valid), .o_app_ready(app_ready),
        .i_seg_rx_valid(seg_rx_valid), .i_seg_rx_flags(seg_rx_flags),
        .i_tx_busy(tx_busy), .o_tx_strobe(tx_strobe), .o_tx_flag(tx_flag),
        .o_conn_up(conn_up), .o_conn_err(conn_err), .o_state(state)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [5:0] flags; } exp_t;
    exp_t sbq[$];
    int total = 0;
    int bad = 0;
    int ecount = 0;

    // Reference model: deadlines are absolute edge numbers instead of counters
    int m_state = 0, m_retry = 0, m_last = -10, m_rto_due = 0, m_ack_due = 0;
    bit m_need = 0, m_synack = 0, m_fin = 0;

    task automatic m_send(input int e, input logic [5:0] f);
        exp_t x;
        x.cyc = e;
        x.flags = f;
        sbq.push_back(x);
        m_last = e;
    endtask

    always @(posedge clk) begin : model
        int e;
        bit gate, rr, sa, psh, fn;
        e = ecount;
        if (rst) begin
            m_state = 0; m_retry = 0; m_last = -10;
            m_need = 0; m_synack = 0; m_fin = 0;
        end else begin
            gate = !tx_busy && (m_last != e - 1);
            rr  = seg_rx_valid && seg_rx_flags[2];
            sa  = seg_rx_valid && seg_rx_flags[4] && seg_rx_flags[1];
            psh = seg_rx_valid && seg_rx_flags[3];
            fn  = seg_rx_valid && seg_rx_flags[0];
            case (m_state)
                0, 4: if (open_req && gate) begin
                    m_send(e, SYN); m_state = 1; m_retry = 0; m_rto_due = e + RTO; m_synack = 0;
                end
                1: begin
                    if (rr) m_state = 4;
                    else if (m_synack || sa) begin
                        if (gate) begin m_send(e, ACK); m_state = 2; m_need = 0; m_synack = 0; end
                        else m_synack = 1;
                    end else if (e >= m_rto_due) begin
                        if (m_retry == MR) m_state = 4;
                        else if (gate) begin m_send(e, SYN); m_retry++; m_rto_due = e + RTO; end
                    end
                end
                2: begin
                    if (rr) begin m_state = 4; m_need = 0; end
                    else if (close_req) begin
                        if (gate) begin
                            m_send(e, FINACK); m_state = 3; m_rto_due = e + RTO;
                            m_retry = 0; m_fin = 0; m_need = 0;
                        end
                    end else begin
                        if (app_valid && gate) begin m_send(e, m_need ? (PSH | ACK) : PSH); m_need = 0; end
                        else if (m_need && e >= m_ack_due && gate) begin m_send(e, ACK); m_need = 0; end
                        if (psh && !m_need) begin m_need = 1; m_ack_due = e + AD; end
                    end
                end
                3: begin
                    if (rr) m_state = 0;
                    else if (m_fin || fn) begin
                        if (gate) begin m_send(e, ACK); m_state = 0; m_fin = 0; end
                        else m_fin = 1;
                    end else if (e >= m_rto_due) begin
                        if (m_retry == MR) m_state = 4;
                        else if (gate) begin m_send(e, FINACK); m_retry++; m_rto_due = e + RTO; end
                    end
                end
                default: m_state = 0;
            endcase
        end
        ecount = ecount + 1;
    end

    always @(negedge clk) begin : monitor
        int e;
        exp_t x;
        bit exp_rdy;
        if (ecount > 0) begin
            e = ecount - 1;
            total++;
            if ({state, conn_up, conn_err} !== {3'(m_state), m_state == 2, m_state == 4}) begin
                bad++;
                $display("FAIL state edge=%0d got state=%0d up=%b err=%b want state=%0d", e, state, conn_up, conn_err, m_state);
            end
            exp_rdy = (m_state == 2) && !tx_busy && (m_last != e) && !close_req;
            total++;
            if (app_ready !== exp_rdy) begin
                bad++;
                $display("FAIL app_ready edge=%0d got=%b want=%b", e, app_ready, exp_rdy);
            end
            if (tx_strobe === 1'b1) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_strobe edge=%0d got flags=%b want none", e, tx_flag);
                end else begin
                    x = sbq.pop_front();
                    if (x.cyc != e || x.flags !== tx_flag) begin
                        bad++;
                        $display("FAIL strobe got edge=%0d flags=%b want edge=%0d flags=%b", e, tx_flag, x.cyc, x.flags);
                    end
                end
            end else begin
                total++;
                if (tx_flag !== 6'b0 || tx_strobe !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_flag edge=%0d got strobe=%b flags=%b want 0", e, tx_strobe, tx_flag);
                end
                if (sbq.size() > 0 && sbq[0].cyc <= e) begin
                    total++;
                    bad++;
                    x = sbq.pop_front();
                    $display("FAIL missing_strobe edge=%0d got none want edge=%0d flags=%b", e, x.cyc, x.flags);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rx(input logic [5:0] f);
        seg_rx_valid = 1'b1;
        seg_rx_flags = f;
        cyc(1);
        seg_rx_valid = 1'b0;
        seg_rx_flags = '0;
    endtask

    task automatic connect();
        open_req = 1'b1; cyc(1); open_req = 1'b0;
        cyc(2); rx(SYNACK); cyc(3);
    endtask

    initial begin
        int app_pct;
        int k;
        rst = 1'b1; cyc(3); rst = 1'b0; cyc(2);

        connect();
        rx(PSH); cyc(12);                                        // pure delayed ACK
        rx(PSH); cyc(2); app_valid = 1'b1; cyc(1); app_valid = 1'b0; cyc(12);  // piggy-back
        rx(PSH); tx_busy = 1'b1; cyc(15); tx_busy = 1'b0; cyc(4);              // ACK held by busy

        close_req = 1'b1; app_valid = 1'b1; seg_rx_valid = 1'b1; seg_rx_flags = PSH;
        cyc(1);
        close_req = 1'b0; app_valid = 1'b0; seg_rx_valid = 1'b0; seg_rx_flags = '0;
        cyc(3); rx(FIN); cyc(3);

        open_req = 1'b1; cyc(1); open_req = 1'b0; cyc(55);       // retry exhaustion
        connect();

        close_req = 1'b1; cyc(1); close_req = 1'b0;              // FIN retransmit held by busy
        tx_busy = 1'b1; cyc(25); tx_busy = 1'b0; cyc(3); rx(FIN); cyc(3);

        connect(); rx(RSTF); cyc(3);
        connect(); app_valid = 1'b1; cyc(1); app_valid = 1'b0;
        rst = 1'b1; cyc(1); rst = 1'b0; cyc(2);
        connect(); app_valid = 1'b1; rst = 1'b1; cyc(1); app_valid = 1'b0; rst = 1'b0; cyc(3);

        app_pct = 20;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) app_pct = $urandom_range(0, 40);
            open_req  = ($urandom_range(0, 99) < 15);
            close_req = ($urandom_range(0, 99) < 4);
            app_valid = ($urandom_range(0, 99) < app_pct);
            tx_busy   = ($urandom_range(0, 99) < 20);
            rst       = ($urandom_range(0, 999) < 3);
            if ($urandom_range(0, 99) < 12) begin
                seg_rx_valid = 1'b1;
                k = $urandom_range(0, 9);
                if (k <= 2)      seg_rx_flags = SYNACK;
                else if (k <= 5) seg_rx_flags = PSH;
                else if (k <= 7) seg_rx_flags = FIN;
                else if (k == 8) seg_rx_flags = ($urandom_range(0, 3) == 0) ? RSTF : ACK;
                else             seg_rx_flags = 6'($urandom);
            end else begin
                seg_rx_valid = 1'b0;
                seg_rx_flags = '0;
            end
            cyc(1);
        end

        open_req = 1'b0; close_req = 1'b0; app_valid = 1'b0; tx_busy = 1'b0;
        rst = 1'b0; seg_rx_valid = 1'b0; seg_rx_flags = '0;
        cyc(5);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL leftover got=%0d pending want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
